// File: rtl/latch_bank_pkg.sv
// Shared defaults and helpers for the multi-channel latch bank.
package latch_bank_pkg;

  localparam int LB_NCH         = 4;
  localparam int LB_WIDTH       = 8;
  localparam int LB_STALE_LIMIT = 15;

  // Counter width that can just hold the saturation value.
  function automatic int age_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/latch_bank_chan.sv
// One latch channel: held data, valid flag, saturating age counter and stale flag.
// Optional change-detect pulse when LATCH_BANK_CHANGE_DETECT_EN is defined.
module latch_bank_chan
  import latch_bank_pkg::*;
#(
  parameter int WIDTH       = LB_WIDTH,
  parameter int STALE_LIMIT = LB_STALE_LIMIT,
  parameter int AGE_W       = age_width(LB_STALE_LIMIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             latch_en,
  input  logic             freeze,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             stale
`ifdef LATCH_BANK_CHANGE_DETECT_EN
  , output logic           changed
`endif
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STALE_LIMIT);

  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] age_next;
  logic             capture;

  assign capture  = latch_en && !freeze;
  assign age_next = (age == AGE_MAX) ? age : age + 1'b1;

  // stale is derived from the post-edge age so it rises on the same edge that age hits the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      valid    <= 1'b0;
      age      <= '0;
      stale    <= 1'b0;
    end else if (clear) begin
      data_out <= '0;
      valid    <= 1'b0;
      age      <= '0;
      stale    <= 1'b0;
    end else if (capture) begin
      data_out <= data_in;
      valid    <= 1'b1;
      age      <= '0;
      stale    <= 1'b0;
    end else if (valid) begin
      age      <= age_next;
      stale    <= (age_next == AGE_MAX);
    end else begin
      age      <= '0;
      stale    <= 1'b0;
    end
  end

`ifdef LATCH_BANK_CHANGE_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
    end else if (clear) begin
      changed <= 1'b0;
    end else begin
      changed <= capture && (!valid || (data_in != data_out));
    end
  end
`endif

endmodule

// File: rtl/latch_bank_nch.sv
// NCH-channel clocked latch bank with per-channel age/stale tracking.
// Change detection output is added when LATCH_BANK_CHANGE_DETECT_EN is defined.
module latch_bank_nch
  import latch_bank_pkg::*;
#(
  parameter int NCH         = LB_NCH,
  parameter int WIDTH       = LB_WIDTH,
  parameter int STALE_LIMIT = LB_STALE_LIMIT,
  parameter int AGE_W       = age_width(STALE_LIMIT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       latch_en,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic                 freeze,
  input  logic                 clear,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH-1:0]       valid,
  output logic [NCH-1:0]       stale
`ifdef LATCH_BANK_CHANGE_DETECT_EN
  , output logic [NCH-1:0]     changed
`endif
);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      latch_bank_chan #(
        .WIDTH       (WIDTH),
        .STALE_LIMIT (STALE_LIMIT),
        .AGE_W       (AGE_W)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .latch_en (latch_en[gi]),
        .freeze   (freeze),
        .clear    (clear),
        .data_in  (data_in[gi*WIDTH +: WIDTH]),
        .data_out (data_out[gi*WIDTH +: WIDTH]),
        .valid    (valid[gi]),
        .stale    (stale[gi])
`ifdef LATCH_BANK_CHANGE_DETECT_EN
        , .changed (changed[gi])
`endif
      );
    end
  endgenerate

endmodule
